driver_bus_rtc: RTL

DRIVER_BUS_RTC -- requirements
Module: driver_bus_rtc

---
 rtl/driver_bus_rtc_pkg.sv | 53 +++++
 rtl/driver_bus_rtc_timer.sv | 28 ++
 rtl/driver_bus_rtc.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/driver_bus_rtc_pkg.sv
// Shared types and constants for the RTC multiplexed-bus driver.
package driver_bus_rtc_pkg;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned BUS_W    = 8;

  localparam int unsigned T_SU_DEF = 2;
  localparam int unsigned T_PW_DEF = 10;
  localparam int unsigned T_HD_DEF = 2;

  // MC146818-style RTC register map
  localparam logic [BUS_W-1:0] RTC_SECONDS    = 8'h00;
  localparam logic [BUS_W-1:0] RTC_SEC_ALARM  = 8'h01;
  localparam logic [BUS_W-1:0] RTC_MINUTES    = 8'h02;
  localparam logic [BUS_W-1:0] RTC_MIN_ALARM  = 8'h03;
  localparam logic [BUS_W-1:0] RTC_HOURS      = 8'h04;
  localparam logic [BUS_W-1:0] RTC_HOUR_ALARM = 8'h05;
  localparam logic [BUS_W-1:0] RTC_DAY_WEEK   = 8'h06;
  localparam logic [BUS_W-1:0] RTC_DATE       = 8'h07;
  localparam logic [BUS_W-1:0] RTC_MONTH      = 8'h08;
  localparam logic [BUS_W-1:0] RTC_YEAR       = 8'h09;
  localparam logic [BUS_W-1:0] RTC_REG_A      = 8'h0A;
  localparam logic [BUS_W-1:0] RTC_REG_B      = 8'h0B;
  localparam logic [BUS_W-1:0] RTC_REG_C      = 8'h0C;
  localparam logic [BUS_W-1:0] RTC_REG_D      = 8'h0D;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADR_SU   = 4'd1,
    ADR_PW   = 4'd2,
    ADR_HD   = 4'd3,
    DAT_SU   = 4'd4,
    DAT_PW   = 4'd5,
    DAT_HD   = 4'd6,
    DONE     = 4'd7,
    WAIT_REL = 4'd8
  } state_t;

  // Captured transaction request
  typedef struct packed {
    logic             wr;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] data;
  } rtc_req_t;

  // Total chip-select low time of one transaction
  function automatic int unsigned cs_low_cycles(input int unsigned su,
                                                input int unsigned pw,
                                                input int unsigned hd);
    return 2 * (su + pw + hd);
  endfunction

endpackage

// File: rtl/driver_bus_rtc_timer.sv
// Loadable down-counter timing each bus phase; last_c flags the final cycle.
module rtc_phase_timer
  import driver_bus_rtc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last_c
);

  logic [CNT_W-1:0] count;

  // Load at phase entry, otherwise count down and stop at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last_c = (count == CNT_W'(1));

endmodule

// File: rtl/driver_bus_rtc.sv
// Drives one RTC register read or write over a multiplexed AD bus.
module driver_bus_rtc
  import driver_bus_rtc_pkg::*;
#(
  parameter int unsigned T_SU = T_SU_DEF,
  parameter int unsigned T_PW = T_PW_DEF,
  parameter int unsigned T_HD = T_HD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             actesc,
  input  logic             actlec,
  input  logic [BUS_W-1:0] dir,
  input  logic [BUS_W-1:0] dato,
  output logic             esclisto,
  output logic             memorialisto,
  output logic [BUS_W-1:0] datomem,
  output logic             cs_n,
  output logic             rd_n,
  output logic             wr_n,
  output logic             ad_n,
  output logic [BUS_W-1:0] ad_out,
  output logic             ad_oe,
  input  logic [BUS_W-1:0] ad_in
);

  localparam logic [CNT_W-1:0] SU_LD = CNT_W'(T_SU);
  localparam logic [CNT_W-1:0] PW_LD = CNT_W'(T_PW);
  localparam logic [CNT_W-1:0] HD_LD = CNT_W'(T_HD);

  state_t           state, state_nxt;
  rtc_req_t         req_q, req_nxt;
  logic             start;
  logic             tmr_load, tmr_dec, tmr_last;
  logic [CNT_W-1:0] tmr_val;

  logic             cs_n_nxt, rd_n_nxt, wr_n_nxt, ad_n_nxt, ad_oe_nxt;
  logic             esc_nxt, mem_nxt;
  logic [BUS_W-1:0] ad_out_nxt;

  // Write wins when both requests arrive together
  assign start   = actesc || actlec;
  assign req_nxt = ((state == IDLE) && start) ?
                   rtc_req_t'{wr: actesc, addr: dir, data: dato} : req_q;

  rtc_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .last_c   (tmr_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture; later input changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
    end else begin
      req_q <= req_nxt;
    end
  end

  // Next-state and phase-timer control
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ADR_SU;
          tmr_load  = 1'b1;
          tmr_val   = SU_LD;
        end
      end
      ADR_SU: begin
        if (tmr_last) begin
          state_nxt = ADR_PW;
          tmr_load  = 1'b1;
          tmr_val   = PW_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ADR_PW: begin
        if (tmr_last) begin
          state_nxt = ADR_HD;
          tmr_load  = 1'b1;
          tmr_val   = HD_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ADR_HD: begin
        if (tmr_last) begin
          state_nxt = DAT_SU;
          tmr_load  = 1'b1;
          tmr_val   = SU_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DAT_SU: begin
        if (tmr_last) begin
          state_nxt = DAT_PW;
          tmr_load  = 1'b1;
          tmr_val   = PW_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DAT_PW: begin
        if (tmr_last) begin
          state_nxt = DAT_HD;
          tmr_load  = 1'b1;
          tmr_val   = HD_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DAT_HD: begin
        if (tmr_last) begin
          state_nxt = DONE;
          tmr_load  = 1'b1;
          tmr_val   = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (!actesc && !actlec) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pin values for the upcoming state, so registered pins line up with it
  always_comb begin
    cs_n_nxt   = 1'b1;
    rd_n_nxt   = 1'b1;
    wr_n_nxt   = 1'b1;
    ad_n_nxt   = 1'b1;
    ad_oe_nxt  = 1'b0;
    ad_out_nxt = '0;
    esc_nxt    = 1'b0;
    mem_nxt    = 1'b0;
    unique case (state_nxt)
      ADR_SU, ADR_PW, ADR_HD: begin
        cs_n_nxt   = 1'b0;
        ad_n_nxt   = 1'b0;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = req_nxt.addr;
        wr_n_nxt   = (state_nxt != ADR_PW);
      end
      DAT_SU, DAT_PW, DAT_HD: begin
        cs_n_nxt = 1'b0;
        ad_n_nxt = 1'b1;
        if (req_nxt.wr) begin
          ad_oe_nxt  = 1'b1;
          ad_out_nxt = req_nxt.data;
          wr_n_nxt   = (state_nxt != DAT_PW);
        end else begin
          rd_n_nxt   = (state_nxt != DAT_PW);
        end
      end
      DONE: begin
        esc_nxt = req_nxt.wr;
        mem_nxt = !req_nxt.wr;
      end
      default: begin
        cs_n_nxt = 1'b1;
      end
    endcase
  end

  // Registered pins and done pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_n         <= 1'b1;
      rd_n         <= 1'b1;
      wr_n         <= 1'b1;
      ad_n         <= 1'b1;
      ad_oe        <= 1'b0;
      ad_out       <= '0;
      esclisto     <= 1'b0;
      memorialisto <= 1'b0;
    end else begin
      cs_n         <= cs_n_nxt;
      rd_n         <= rd_n_nxt;
      wr_n         <= wr_n_nxt;
      ad_n         <= ad_n_nxt;
      ad_oe        <= ad_oe_nxt;
      ad_out       <= ad_out_nxt;
      esclisto     <= esc_nxt;
      memorialisto <= mem_nxt;
    end
  end

  // Read data sampled at the end of the read strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      datomem <= '0;
    end else if ((state == DAT_PW) && tmr_last && !req_q.wr) begin
      datomem <= ad_in;
    end
  end

endmodule
